// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the ARM64 pipelined CPU EX/MEM boundary.
//   cond_e   : 4-bit B.cond condition code encoding (ARM numbering).
//   nzcv_t   : architectural flags, packed so bit 3..0 = N,Z,C,V.
//   ex_mem_t : payload carried from EX into the MEM-side pipeline register.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 64;  // datapath width
  localparam int REGW = 5;   // register-index width

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF   // behaves as "always" on ARMv8
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_mem_t;

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational B.cond evaluator, shared with decode.
// Ports:
//   cond  in  cond_e  condition code
//   f     in  nzcv_t  flags to test against
//   taken out 1       condition holds
// -----------------------------------------------------------------------------
module cond_eval
  import cpu_pkg::*;
(
  input  cond_e cond,
  input  nzcv_t f,
  output logic  taken
);

  // Signed "greater or equal" is N==V after a SUBS; computed once and reused.
  logic n_eq_v;
  assign n_eq_v = (f.n == f.v);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = f.z;
      COND_NE: taken = ~f.z;
      COND_CS: taken = f.c;
      COND_CC: taken = ~f.c;
      COND_MI: taken = f.n;
      COND_PL: taken = ~f.n;
      COND_VS: taken = f.v;
      COND_VC: taken = ~f.v;
      COND_HI: taken = f.c & ~f.z;
      COND_LS: taken = ~f.c | f.z;
      COND_GE: taken = n_eq_v;
      COND_LT: taken = ~n_eq_v;
      COND_GT: taken = ~f.z & n_eq_v;
      COND_LE: taken = f.z | ~n_eq_v;
      default: taken = 1'b1;  // AL and NV
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register directly after the 64-bit ALU. Latches the ALU
// result plus memory/writeback control with a valid/ready handshake, owns the
// architectural NZCV register (written only by ADDS/SUBS), and evaluates
// B.cond for decode against the freshest flags (bypassing the ALU flags when
// the instruction in EX sets them).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        EX-side handshake
//   alu_result, store_data     W-bit data from EX
//   negative, zero,
//   overflow, carry_out        ALU flags
//   set_flags                  EX instruction is ADDS/SUBS
//   rd, reg_write, mem_read,
//   mem_write                  destination and control from EX
//   flush                      discard the EX instruction
//   out_valid / out_ready      MEM-side handshake
//   mem_result, mem_store_data,
//   mem_rd                     registered payload
//   mem_reg_write, mem_mem_read,
//   mem_mem_write              registered control, forced low on a bubble
//   flags                      architectural NZCV (bit 3..0 = N,Z,C,V)
//   cond / cond_taken          B.cond query from decode and its result
// -----------------------------------------------------------------------------
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int W  = XLEN,  // must match cpu_pkg::XLEN (payload struct width)
  parameter int RW = REGW   // must match cpu_pkg::REGW
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  alu_result,
  input  logic          negative,
  input  logic          zero,
  input  logic          overflow,
  input  logic          carry_out,
  input  logic          set_flags,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [W-1:0]  store_data,
  input  logic          flush,

  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  mem_result,
  output logic [W-1:0]  mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,

  output logic [3:0]    flags,
  input  logic [3:0]    cond,
  output logic          cond_taken
);

  ex_mem_t payload_reg;
  logic    out_valid_reg;
  nzcv_t   flags_reg;

  nzcv_t   alu_flags;
  nzcv_t   fwd_flags;
  logic    accept;
  logic    ex_sets_flags;

  // Ready depends only on the output side so it never combinationally
  // loops back through in_valid.
  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  assign alu_flags = nzcv_t'({negative, zero, carry_out, overflow});

  // Bypass: a flag-setter sitting in EX (and not being killed) is the
  // youngest producer of NZCV, even if the stage is stalled and it has not
  // committed yet. Decode must see its flags, not the stale register.
  assign ex_sets_flags = in_valid & set_flags & ~flush;
  assign fwd_flags     = ex_sets_flags ? alu_flags : flags_reg;

  cond_eval u_cond_eval (
    .cond  (cond_e'(cond)),
    .f     (fwd_flags),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      payload_reg   <= '0;
      flags_reg     <= '0;
    end else begin
      if (accept) begin
        out_valid_reg          <= 1'b1;
        payload_reg.result     <= alu_result;
        payload_reg.store_data <= store_data;
        payload_reg.rd         <= rd;
        payload_reg.reg_write  <= reg_write;
        payload_reg.mem_read   <= mem_read;
        payload_reg.mem_write  <= mem_write;
        // Flags commit together with the instruction that produced them.
        if (set_flags) begin
          flags_reg <= alu_flags;
        end
      end else if (out_ready) begin
        // Drained with nothing new behind it: becomes a bubble, data holds.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_reg;
  assign mem_result     = payload_reg.result;
  assign mem_store_data = payload_reg.store_data;
  assign mem_rd         = payload_reg.rd;

  // Stale control left in the register after a drain must never write.
  assign mem_reg_write  = out_valid_reg & payload_reg.reg_write;
  assign mem_mem_read   = out_valid_reg & payload_reg.mem_read;
  assign mem_mem_write  = out_valid_reg & payload_reg.mem_write;

  assign flags = flags_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
// Scoreboard bench for ex_mem_stage: the driver keeps a behavioural model of
// the stage (occupancy bit, flag register, FIFO of accepted instructions) and
// a monitor pops and compares each instruction MEM consumes.
// -----------------------------------------------------------------------------
module tb_ex_mem_stage;

  localparam int W  = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  alu_result = '0;
  logic          negative = 1'b0;
  logic          zero = 1'b0;
  logic          overflow = 1'b0;
  logic          carry_out = 1'b0;
  logic          set_flags = 1'b0;
  logic [RW-1:0] rd = '0;
  logic          reg_write = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [W-1:0]  store_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  mem_result;
  logic [W-1:0]  mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic [3:0]    flags;
  logic [3:0]    cond = '0;
  logic          cond_taken;

  always #5 clk = ~clk;

  ex_mem_stage #(.W(W), .RW(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .negative       (negative),
    .zero           (zero),
    .overflow       (overflow),
    .carry_out      (carry_out),
    .set_flags      (set_flags),
    .rd             (rd),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .store_data     (store_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .flags          (flags),
    .cond           (cond),
    .cond_taken     (cond_taken)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic [W-1:0]  sd;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       model_valid = 1'b0;
  logic [3:0] model_flags = 4'b0000;
  int         txn_count = 0;

  // ARM condition semantics straight from the architecture definition.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: apply inputs, check combinational/state outputs
  // against the model, then advance the model across the coming edge.
  task automatic cycle(input logic iv, input logic sf, input logic fl, input logic ordy,
                       input logic [3:0] nzcv, input logic [W-1:0] res,
                       input logic [W-1:0] sd, input logic [RW-1:0] r,
                       input logic rw, input logic mr, input logic mw,
                       input logic [3:0] c);
    logic       rdy, acc;
    logic [3:0] fwd;
    exp_t       e;
    @(posedge clk);
    #1;
    in_valid   = iv;
    set_flags  = sf;
    flush      = fl;
    out_ready  = ordy;
    {negative, zero, carry_out, overflow} = nzcv;
    alu_result = res;
    store_data = sd;
    rd         = r;
    reg_write  = rw;
    mem_read   = mr;
    mem_write  = mw;
    cond       = c;
    #3;
    rdy = !model_valid || ordy;
    fwd = (iv && sf && !fl) ? nzcv : model_flags;
    check1("in_ready", in_ready, rdy);
    check1("out_valid", out_valid, model_valid);
    checkw("flags", W'(flags), W'(model_flags));
    check1("cond_taken", cond_taken, ref_cond(c, fwd));
    acc = iv && rdy && !fl;
    if (acc) begin
      e = '{res: res, sd: sd, rd: r, rw: rw, mr: mr, mw: mw};
      sb_q.push_back(e);
      if (sf) model_flags = nzcv;
    end
    model_valid = acc || (model_valid && !ordy);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, ordy, 4'b0000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 4'hE);
  endtask

  task automatic rand_cycle();
    cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), 4'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, RW'($urandom), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    set_flags = 1'b0;
    flush = 1'b0;
    cond = 4'd0;
    rst_n = 1'b0;
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    checkw("reset_flags", W'(flags), W'(4'b0000));
    checkw("reset_mem_result", mem_result, '0);
    check1("reset_eq", cond_taken, 1'b0);
    cond = 4'd1;
    #1;
    check1("reset_ne", cond_taken, 1'b1);
    sb_q.delete();
    model_valid = 1'b0;
    model_flags = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare whatever MEM consumes against the scoreboard front.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: DUT presented result %0h, expected no instruction", mem_result);
          end else begin
            e = sb_q.pop_front();
            txn_count++;
            checkw("mem_result", mem_result, e.res);
            checkw("mem_store_data", mem_store_data, e.sd);
            checkw("mem_rd", W'(mem_rd), W'(e.rd));
            check1("mem_reg_write", mem_reg_write, e.rw);
            check1("mem_mem_read", mem_mem_read, e.mr);
            check1("mem_mem_write", mem_mem_write, e.mw);
            $display("txn %0d: rd=%0d result=%h store=%h rw=%b mr=%b mw=%b flags=%b",
                     txn_count, mem_rd, mem_result, mem_store_data,
                     mem_reg_write, mem_mem_read, mem_mem_write, flags);
          end
        end else if (!out_valid) begin
          check1("bubble_reg_write", mem_reg_write, 1'b0);
          check1("bubble_mem_read", mem_mem_read, 1'b0);
          check1("bubble_mem_write", mem_mem_write, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // SUBS 5-5: zero result, Z=1 C=1; EQ taken via bypass in the same cycle.
    cycle(1, 1, 0, 1, 4'b0110, 64'd0, 64'd0, 5'd3, 1, 0, 0, 4'd0);
    // Plain ADD with N=1 must not touch flags; LT on 0110 is false.
    cycle(1, 0, 0, 1, 4'b1000, 64'd42, 64'd0, 5'd4, 1, 0, 0, 4'd11);
    checkw("flags_after_add", W'(flags), W'(4'b0110));

    // Stall: out_ready low for 3 cycles, ADDS offered meanwhile is refused.
    cycle(1, 0, 0, 1, 4'b0000, 64'h1234, 64'h55, 5'd7, 0, 0, 1, 4'hE);
    cycle(1, 1, 0, 0, 4'b1111, 64'hdead, 64'd0, 5'd8, 1, 0, 0, 4'd0);
    held = mem_result;
    checkw("stall_hold_value", held, 64'h1234);
    cycle(1, 1, 0, 0, 4'b1111, 64'hdead, 64'd0, 5'd8, 1, 0, 0, 4'd6);
    cycle(1, 1, 0, 0, 4'b1111, 64'hdead, 64'd0, 5'd8, 1, 0, 0, 4'd4);
    checkw("stall_mem_result", mem_result, held);
    checkw("stall_flags", W'(flags), W'(4'b0110));
    idle(1'b1);

    // Flush of a flag-setter with V=1: discarded, flags untouched.
    cycle(1, 1, 1, 1, 4'b0001, 64'hbad, 64'd0, 5'd9, 1, 1, 1, 4'd6);
    idle(1'b1);
    checkw("flush_flags", W'(flags), W'(4'b0110));
    check1("flush_no_write", mem_reg_write, 1'b0);

    // Back-to-back at full throughput.
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 0, 1, 4'b0000, 64'(100 + i), 64'(i), RW'(10 + i), 1, 0, 0, 4'hE);
    idle(1'b1);

    // Signed-compare truth table on all 16 NZCV values, through the bypass.
    for (int nz = 0; nz < 16; nz++)
      for (int c = 10; c < 14; c++)
        cycle(1, 1, 0, 1, 4'(nz), 64'(nz), '0, RW'(c), 0, 0, 0, 4'(c));

    for (int i = 0; i < 400; i++) rand_cycle();

    // Reset mid-stream with an instruction held under stall.
    cycle(1, 1, 0, 1, 4'b1010, 64'h77, 64'd0, 5'd1, 1, 1, 0, 4'hE);
    cycle(0, 0, 0, 0, 4'b0000, 64'd0, 64'd0, 5'd0, 0, 0, 0, 4'hE);
    do_reset();

    for (int i = 0; i < 200; i++) rand_cycle();
    repeat (4) idle(1'b1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d instructions never emerged, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
